// File: rtl/ats_multi_timer.sv
// rtl/ats_multi_timer.sv - parametrised counters and alarms driven by two beat-serial clients
module ats_multi_timer #(
    parameter int NUM_CLOCKS = 16,
    parameter int NUM_ALARMS = 24,
    parameter int COUNT_W    = 16,
    parameter int PULSE_LEN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [15:0]           ctrlA,
    input  logic [15:0]           ctrlB,
    output logic                  ready,
    output logic [1:0]            stat,
    output logic [NUM_ALARMS-1:0] data
);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1);
    localparam logic [PW-1:0]      PULSE_INIT = PW'(PULSE_LEN);

    localparam logic [2:0] OP_SETCLK = 3'b001;
    localparam logic [2:0] OP_CLKEN  = 3'b010;
    localparam logic [2:0] OP_MODE   = 3'b011;
    localparam logic [2:0] OP_SETALM = 3'b101;
    localparam logic [2:0] OP_CDOWN  = 3'b110;
    localparam logic [2:0] OP_ALMEN  = 3'b111;

    typedef enum logic {S_IDLE, S_TOP} state_t;

    state_t               st_q [2];
    state_t               st_d [2];
    logic [15:0]          top_q [2];
    logic [15:0]          top_d [2];
    logic [2:0]           presc_q;
    logic [COUNT_W-1:0]   cnt_q [NUM_CLOCKS];
    logic [COUNT_W-1:0]   cnt_d [NUM_CLOCKS];
    logic [1:0]           rate_q [NUM_CLOCKS];
    logic [1:0]           rate_d [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] cen_q, cen_d;
    logic [COUNT_W-1:0]   aval_q [NUM_ALARMS];
    logic [COUNT_W-1:0]   aval_d [NUM_ALARMS];
    logic [3:0]           aclk_q [NUM_ALARMS];
    logic [3:0]           aclk_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] aen_q, aen_d, arep_q, arep_d;
    logic [PW-1:0]        pulse_q [NUM_ALARMS];
    logic [PW-1:0]        pulse_d [NUM_ALARMS];
    logic                 active_q, active_d;
    logic [1:0]           pclk_q, pclk_d, palm_q, palm_d;
    logic                 ready_q, ready_d;
    logic [1:0]           stat_q, stat_d;

    logic [15:0]          beat [2];
    logic [31:0]          instr [2];
    logic [2:0]           op [2];
    logic [3:0]           cidx [2];
    logic [4:0]           aidx [2];
    logic [3:0]           asel [2];
    logic [COUNT_W-1:0]   val [2];
    logic [COUNT_W-1:0]   cd_base [2];
    logic [1:0]           exec, legal, apply;
    logic                 conflict;
    logic [3:0]           tick;
    logic [NUM_CLOCKS-1:0] inc, load;
    logic                 unused_bits;

    assign beat[0]     = ctrlA;
    assign beat[1]     = ctrlB;
    assign unused_bits = ^{instr[0][21:20], instr[1][21:20]};

    function automatic logic clk_op(input logic [2:0] o);
        return (o == OP_SETCLK) || (o == OP_CLKEN);
    endfunction

    function automatic logic alm_op(input logic [2:0] o);
        return (o == OP_SETALM) || (o == OP_CDOWN) || (o == OP_ALMEN);
    endfunction

    always_comb begin
        for (int x = 0; x < 2; x++) begin
            st_d[x]  = st_q[x];
            top_d[x] = top_q[x];
            exec[x]  = 1'b0;
            instr[x] = {top_q[x], beat[x]};
            case (st_q[x])
                S_IDLE: if (req && beat[x][15:13] != 3'b000) begin
                    top_d[x] = beat[x];
                    st_d[x]  = S_TOP;
                end
                S_TOP: begin
                    exec[x] = req;
                    st_d[x] = S_IDLE;
                end
                default: st_d[x] = S_IDLE;
            endcase
            op[x]   = instr[x][31:29];
            cidx[x] = instr[x][28:25];
            aidx[x] = instr[x][28:24];
            asel[x] = instr[x][19:16];
            val[x]  = instr[x][COUNT_W-1:0];
        end
    end

    always_comb begin
        for (int x = 0; x < 2; x++) begin
            legal[x] = 1'b0;
            case (op[x])
                OP_SETCLK, OP_CLKEN: legal[x] = active_q && pclk_q[x] && (int'(cidx[x]) < NUM_CLOCKS);
                OP_SETALM: legal[x] = active_q && palm_q[x] && (int'(aidx[x]) < NUM_ALARMS)
                                      && (int'(asel[x]) < NUM_CLOCKS);
                OP_CDOWN:  legal[x] = active_q && palm_q[x] && (int'(aidx[x]) < NUM_ALARMS)
                                      && (int'(asel[x]) < NUM_CLOCKS) && (val[x] != '0);
                OP_ALMEN:  legal[x] = active_q && palm_q[x] && (int'(aidx[x]) < NUM_ALARMS);
                OP_MODE:   legal[x] = 1'b1;
                default:   legal[x] = 1'b0;
            endcase
        end
        conflict = exec[0] && exec[1] &&
                   ((clk_op(op[0]) && clk_op(op[1]) && cidx[0] == cidx[1]) ||
                    (alm_op(op[0]) && alm_op(op[1]) && aidx[0] == aidx[1]) ||
                    (op[0] == OP_MODE && op[1] == OP_MODE));
        apply   = exec & legal & {2{!conflict}};
        ready_d = |exec;
        for (int x = 0; x < 2; x++) begin
            stat_d[x] = exec[x] ? apply[x] : stat_q[x];
        end
    end

    // A clock being loaded this cycle does not count, so alarms on it cannot fire.
    always_comb begin
        tick = {&presc_q, &presc_q[1:0], presc_q[0], 1'b1};
        for (int j = 0; j < NUM_CLOCKS; j++) begin
            inc[j]  = cen_q[j] && active_q && tick[rate_q[j]];
            load[j] = 1'b0;
            for (int x = 0; x < 2; x++) begin
                if (apply[x] && op[x] == OP_SETCLK && int'(cidx[x]) == j) load[j] = 1'b1;
            end
        end
        for (int x = 0; x < 2; x++) begin
            cd_base[x] = '0;
            for (int j = 0; j < NUM_CLOCKS; j++) begin
                if (int'(asel[x]) == j) cd_base[x] = cnt_q[j];
            end
        end
    end

    always_comb begin
        logic               a_hit;
        logic [COUNT_W-1:0] a_cnt;
        logic               wr;
        logic               fire;
        cnt_d    = cnt_q;
        rate_d   = rate_q;
        cen_d    = cen_q;
        aval_d   = aval_q;
        aclk_d   = aclk_q;
        aen_d    = aen_q;
        arep_d   = arep_q;
        pulse_d  = pulse_q;
        active_d = active_q;
        pclk_d   = pclk_q;
        palm_d   = palm_q;
        for (int j = 0; j < NUM_CLOCKS; j++) begin
            if (inc[j]) cnt_d[j] = cnt_q[j] + CNT_ONE;
        end
        for (int x = 0; x < 2; x++) begin
            if (apply[x]) begin
                for (int j = 0; j < NUM_CLOCKS; j++) begin
                    if (int'(cidx[x]) == j) begin
                        if (op[x] == OP_SETCLK) begin
                            cnt_d[j]  = val[x];
                            rate_d[j] = instr[x][23:22];
                            cen_d[j]  = 1'b1;
                        end
                        if (op[x] == OP_CLKEN) cen_d[j] = instr[x][23];
                    end
                end
                if (op[x] == OP_MODE) begin
                    active_d  = instr[x][28];
                    pclk_d[x] = instr[x][27];
                    palm_d[x] = instr[x][26];
                end
            end
        end
        for (int i = 0; i < NUM_ALARMS; i++) begin
            a_hit = 1'b0;
            a_cnt = '0;
            wr    = 1'b0;
            for (int j = 0; j < NUM_CLOCKS; j++) begin
                if (int'(aclk_q[i]) == j) begin
                    a_hit = inc[j] && !load[j];
                    a_cnt = cnt_q[j];
                end
            end
            for (int x = 0; x < 2; x++) begin
                if (apply[x] && alm_op(op[x]) && int'(aidx[x]) == i) wr = 1'b1;
            end
            fire = aen_q[i] && a_hit && (a_cnt + CNT_ONE == aval_q[i]) && !wr;
            if (fire) begin
                pulse_d[i] = PULSE_INIT;
                if (!arep_q[i]) aen_d[i] = 1'b0;
            end else if (pulse_q[i] != '0) begin
                pulse_d[i] = pulse_q[i] - PW'(1);
            end
            for (int x = 0; x < 2; x++) begin
                if (apply[x] && int'(aidx[x]) == i) begin
                    case (op[x])
                        OP_SETALM: begin
                            aval_d[i] = val[x];
                            aclk_d[i] = asel[x];
                            arep_d[i] = instr[x][23];
                            aen_d[i]  = 1'b1;
                        end
                        OP_CDOWN: begin
                            aval_d[i] = cd_base[x] + val[x];
                            aclk_d[i] = asel[x];
                            arep_d[i] = 1'b0;
                            aen_d[i]  = 1'b1;
                        end
                        OP_ALMEN: aen_d[i] = instr[x][23];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int x = 0; x < 2; x++) begin
                st_q[x]  <= S_IDLE;
                top_q[x] <= '0;
            end
            for (int j = 0; j < NUM_CLOCKS; j++) begin
                cnt_q[j]  <= '0;
                rate_q[j] <= '0;
            end
            for (int i = 0; i < NUM_ALARMS; i++) begin
                aval_q[i]  <= '0;
                aclk_q[i]  <= '0;
                pulse_q[i] <= '0;
            end
            presc_q  <= '0;
            cen_q    <= '0;
            aen_q    <= '0;
            arep_q   <= '0;
            active_q <= 1'b1;
            pclk_q   <= 2'b11;
            palm_q   <= 2'b11;
            ready_q  <= 1'b0;
            stat_q   <= 2'b00;
        end else begin
            st_q     <= st_d;
            top_q    <= top_d;
            cnt_q    <= cnt_d;
            rate_q   <= rate_d;
            aval_q   <= aval_d;
            aclk_q   <= aclk_d;
            pulse_q  <= pulse_d;
            presc_q  <= presc_q + 3'd1;
            cen_q    <= cen_d;
            aen_q    <= aen_d;
            arep_q   <= arep_d;
            active_q <= active_d;
            pclk_q   <= pclk_d;
            palm_q   <= palm_d;
            ready_q  <= ready_d;
            stat_q   <= stat_d;
        end
    end

    assign ready = ready_q;
    assign stat  = stat_q;
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) data[i] = (pulse_q[i] != '0);
    end
endmodule

// File: tb/tb_ats_multi_timer.sv
// tb/tb_ats_multi_timer.sv - directed and random checks of ats_multi_timer against a reference model
module tb_ats_multi_timer;
    localparam int NC = 16;
    localparam int NA = 24;
    localparam int CW = 16;
    localparam int PL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic [15:0]   ctrlA, ctrlB;
    logic          ready;
    logic [1:0]    stat;
    logic [NA-1:0] data;

    always #5 clk = ~clk;

    ats_multi_timer #(.NUM_CLOCKS(NC), .NUM_ALARMS(NA), .COUNT_W(CW), .PULSE_LEN(PL)) dut (
        .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
        .ready(ready), .stat(stat), .data(data)
    );

    int errors = 0;
    int checks = 0;

    int          m_cnt [NC];
    int          m_rate [NC];
    bit          m_cen [NC];
    int          m_aval [NA];
    int          m_aclk [NA];
    bit          m_aen [NA];
    bit          m_arep [NA];
    int          m_pulse [NA];
    bit          m_active;
    bit          m_pclk [2];
    bit          m_palm [2];
    int          m_p;
    bit          m_pend [2];
    logic [15:0] m_top [2];
    bit          m_ready;
    logic [1:0]  m_stat;

    function automatic int opc(input logic [31:0] w);
        return int'(w[31:29]);
    endfunction

    function automatic bit legal(input int x, input logic [31:0] w);
        int op = opc(w);
        int ci = int'(w[28:25]);
        int ai = int'(w[28:24]);
        int ac = int'(w[19:16]);
        int du = int'(w[CW-1:0]);
        if (op == 3) return 1'b1;
        if (!m_active) return 1'b0;
        case (op)
            1, 2:    return ci < NC && m_pclk[x];
            5:       return ai < NA && ac < NC && m_palm[x];
            6:       return ai < NA && ac < NC && m_palm[x] && du != 0;
            7:       return ai < NA && m_palm[x];
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit collide(input logic [31:0] a, input logic [31:0] b);
        int oa = opc(a);
        int ob = opc(b);
        if ((oa == 1 || oa == 2) && (ob == 1 || ob == 2) && a[28:25] == b[28:25]) return 1'b1;
        if (oa >= 5 && ob >= 5 && a[28:24] == b[28:24]) return 1'b1;
        return oa == 3 && ob == 3;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NC; j++) begin
            m_cnt[j] = 0; m_rate[j] = 0; m_cen[j] = 1'b0;
        end
        for (int i = 0; i < NA; i++) begin
            m_aval[i] = 0; m_aclk[i] = 0; m_aen[i] = 1'b0; m_arep[i] = 1'b0; m_pulse[i] = 0;
        end
        for (int x = 0; x < 2; x++) begin
            m_pclk[x] = 1'b1; m_palm[x] = 1'b1; m_pend[x] = 1'b0; m_top[x] = '0;
        end
        m_active = 1'b1;
        m_p      = 0;
        m_ready  = 1'b0;
        m_stat   = 2'b00;
    endtask

    // Advances the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        logic [31:0] ins [2];
        logic [15:0] bt [2];
        bit ex [2];
        bit ap [2];
        bit inc [NC];
        bit ld [NC];
        bit wr [NA];
        bit fire [NA];
        int base [2];
        bit conf;
        int per, c, ci, ai, mod;
        mod = 1 << CW;
        bt[0] = ctrlA;
        bt[1] = ctrlB;
        if (reset) begin
            model_reset();
            return;
        end
        for (int x = 0; x < 2; x++) begin
            ex[x]  = 1'b0;
            ins[x] = '0;
            if (m_pend[x]) begin
                if (req) begin
                    ex[x]  = 1'b1;
                    ins[x] = {m_top[x], bt[x]};
                end
                m_pend[x] = 1'b0;
            end else if (req && bt[x][15:13] != 3'b000) begin
                m_pend[x] = 1'b1;
                m_top[x]  = bt[x];
            end
        end
        conf = ex[0] && ex[1] && collide(ins[0], ins[1]);
        for (int x = 0; x < 2; x++) begin
            ap[x]   = ex[x] && !conf && legal(x, ins[x]);
            base[x] = (ap[x] && opc(ins[x]) == 6) ? m_cnt[int'(ins[x][19:16])] : 0;
        end
        for (int j = 0; j < NC; j++) begin
            per    = 1 << m_rate[j];
            inc[j] = m_cen[j] && m_active && (m_p % per == per - 1);
            ld[j]  = 1'b0;
        end
        for (int i = 0; i < NA; i++) wr[i] = 1'b0;
        for (int x = 0; x < 2; x++) begin
            if (ap[x] && opc(ins[x]) == 1) ld[int'(ins[x][28:25])] = 1'b1;
            if (ap[x] && opc(ins[x]) >= 5) wr[int'(ins[x][28:24])] = 1'b1;
        end
        for (int i = 0; i < NA; i++) begin
            c       = m_aclk[i];
            fire[i] = m_aen[i] && inc[c] && !ld[c] && !wr[i] && ((m_cnt[c] + 1) % mod == m_aval[i]);
        end
        for (int j = 0; j < NC; j++) begin
            if (inc[j]) m_cnt[j] = (m_cnt[j] + 1) % mod;
        end
        for (int i = 0; i < NA; i++) begin
            if (fire[i]) begin
                m_pulse[i] = PL;
                if (!m_arep[i]) m_aen[i] = 1'b0;
            end else if (m_pulse[i] > 0) begin
                m_pulse[i] = m_pulse[i] - 1;
            end
        end
        for (int x = 0; x < 2; x++) begin
            if (ap[x]) begin
                ci = int'(ins[x][28:25]);
                ai = int'(ins[x][28:24]);
                case (opc(ins[x]))
                    1: begin
                        m_cnt[ci]  = int'(ins[x][CW-1:0]);
                        m_rate[ci] = int'(ins[x][23:22]);
                        m_cen[ci]  = 1'b1;
                    end
                    2: m_cen[ci] = ins[x][23];
                    3: begin
                        m_active  = ins[x][28];
                        m_pclk[x] = ins[x][27];
                        m_palm[x] = ins[x][26];
                    end
                    5: begin
                        m_aval[ai] = int'(ins[x][CW-1:0]);
                        m_aclk[ai] = int'(ins[x][19:16]);
                        m_arep[ai] = ins[x][23];
                        m_aen[ai]  = 1'b1;
                    end
                    6: begin
                        m_aval[ai] = (base[x] + int'(ins[x][CW-1:0])) % mod;
                        m_aclk[ai] = int'(ins[x][19:16]);
                        m_arep[ai] = 1'b0;
                        m_aen[ai]  = 1'b1;
                    end
                    7: m_aen[ai] = ins[x][23];
                    default: ;
                endcase
            end
        end
        m_p     = (m_p + 1) % 8;
        m_ready = ex[0] || ex[1];
        for (int x = 0; x < 2; x++) begin
            if (ex[x]) m_stat[x] = ap[x];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [NA-1:0] ed;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NA; i++) ed[i] = (m_pulse[i] > 0);
        chk("ready", 32'(ready), 32'(m_ready));
        chk("stat", 32'(stat), 32'(m_stat));
        chk("data", 32'(data), 32'(ed));
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic r);
        ctrlA = a;
        ctrlB = b;
        req   = r;
        step();
    endtask

    task automatic send_a(input logic [15:0] t, input logic [15:0] lo);
        drive(t, 16'h0000, 1'b1);
        drive(lo, 16'h0000, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(16'h0000, 16'h0000, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  op;
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1:    op = 3'b001;
            2:       op = 3'b010;
            3:       op = 3'b011;
            4:       op = 3'b100;
            5, 6:    op = 3'b101;
            7:       op = 3'b110;
            8:       op = 3'b111;
            default: op = 3'b000;
        endcase
        r[31:29] = op;
        r[15:0]  = 16'($urandom_range(0, 40));
        if (op == 3'b011) begin
            r[28] = ($urandom_range(0, 7) != 0);
            r[27] = ($urandom_range(0, 3) != 0);
            r[26] = ($urandom_range(0, 3) != 0);
        end
        if (op == 3'b010 || op == 3'b111) r[23] = ($urandom_range(0, 3) != 0);
        return r;
    endfunction

    initial begin
        int n;
        int first;
        bit seen;
        logic [31:0] ia, ib;
        reset = 1'b1;
        req   = 1'b0;
        ctrlA = '0;
        ctrlB = '0;
        idle(2);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_stat", 32'(stat), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        reset = 1'b0;
        idle(3);

        send_a(16'h2600, 16'h0010);
        chk("t1_stat", 32'(stat), 32'h1);
        chk("t1_ready", 32'(ready), 32'h1);
        idle(1);
        chk("t1_ready_pulse", 32'(ready), 32'h0);
        chk("t1_stat_hold", 32'(stat), 32'h1);

        send_a(16'hA503, 16'h0014);
        chk("t2_stat", 32'(stat), 32'h1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            idle(1);
            if (data[5]) n++;
        end
        chk("t2_pulse_len", 32'(n), 32'd2);
        send_a(16'h2600, 16'h0010);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            idle(1);
            if (data[5]) n++;
        end
        chk("t2_no_refire", 32'(n), 32'd0);

        drive(16'h2600, 16'h2600, 1'b1);
        drive(16'h0010, 16'h0010, 1'b1);
        chk("t3_conflict_stat", 32'(stat), 32'h0);
        chk("t3_conflict_ready", 32'(ready), 32'h1);
        idle(2);

        send_a(16'h20C0, 16'hFFFE);
        chk("t4_setclk", 32'(stat), 32'h1);
        send_a(16'hA180, 16'h0000);
        chk("t4_setalm", 32'(stat), 32'h1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (data[1]) seen = 1'b1;
        end
        chk("t4_wrap_fire", 32'(seen), 32'h1);

        send_a(16'h2000, 16'h0100);
        send_a(16'hC200, 16'h0005);
        chk("t5_stat", 32'(stat), 32'h1);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            idle(1);
            if (data[2] && first == 0) first = k;
        end
        chk("t5_latency", 32'(first), 32'd4);

        send_a(16'h7400, 16'h0000);
        chk("t6_mode_ack", 32'(stat), 32'h1);
        send_a(16'h2600, 16'h0020);
        chk("t6_perm_nack", 32'(stat), 32'h0);
        chk("t6_perm_ready", 32'(ready), 32'h1);
        send_a(16'h7C00, 16'h0000);
        send_a(16'h2600, 16'h0003);
        chk("t6_restored", 32'(stat), 32'h1);
        drive(16'h2600, 16'h0000, 1'b1);
        drive(16'h0000, 16'h0000, 1'b0);
        chk("t6_abort_ready", 32'(ready), 32'h0);
        idle(1);
        drive(16'h2600, 16'h0000, 1'b1);
        reset = 1'b1;
        drive(16'h0010, 16'h0000, 1'b1);
        chk("t6_rst_ready", 32'(ready), 32'h0);
        chk("t6_rst_stat", 32'(stat), 32'h0);
        chk("t6_rst_data", 32'(data), 32'h0);
        reset = 1'b0;
        idle(2);

        for (int k = 0; k < 400; k++) begin
            ia = rand_instr();
            ib = ($urandom_range(0, 2) == 0) ? 32'h0 : rand_instr();
            drive(ia[31:16], ib[31:16], 1'b1);
            drive(ia[15:0], ib[15:0], ($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
            if (k % 101 == 100) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
